// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises up to 8 sources, latches edge/level events, drives irq_n (and nmi_n under IRQC_NMI_EN).
// Latency: src -> PENDING SYNC_STAGES+1 clocks, PENDING/ENABLE -> irq_n +1 clock, read data registered (1 clock).
// Backpressure: none; every cs&strobe access completes in its own cycle and sources are sampled every clock.
module irq_ctrl #(
    parameter int                  CHANNELS    = 8,
    parameter int                  SYNC_STAGES = 2,
    parameter logic [CHANNELS-1:0] RESET_MASK  = '0,
    parameter int                  NMI_PULSE   = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] src,
    input  logic                cs,
    input  logic                strobe,
    input  logic                rw,
    input  logic [2:0]          reg_addr,
    input  logic [7:0]          wdata,
    output logic [7:0]          rdata,
    output logic                irq_n,
    output logic                nmi_n
);

    localparam logic [2:0] A_STATUS  = 3'd0;
    localparam logic [2:0] A_PENDING = 3'd1;
    localparam logic [2:0] A_ENABLE  = 3'd2;
    localparam logic [2:0] A_MODE    = 3'd3;
    localparam logic [2:0] A_POL     = 3'd4;
    localparam logic [2:0] A_ACTIVE  = 3'd5;
    localparam logic [2:0] A_SOFT    = 3'd6;

`ifdef IRQC_NMI_EN
    localparam logic [CHANNELS-1:0] NMI_MASK = CHANNELS'(1);
`else
    localparam logic [CHANNELS-1:0] NMI_MASK = '0;
`endif

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
    logic [CHANNELS-1:0] pending, enable, mode, polarity, hist;
    logic [CHANNELS-1:0] s, wdata_ch, edge_ev, soft_set, w1c, mode_chg, mode_eff;
    logic [CHANNELS-1:0] irq_src, pending_next, hist_next;
    logic                access, wr, rd;
    logic [7:0]          rd_mux;
    logic [2:0]          act_idx;

    assign s        = sync_q[SYNC_STAGES-1] ^ polarity;
    assign wdata_ch = wdata[CHANNELS-1:0];
    assign access   = cs & strobe;
    assign wr       = access & ~rw;
    assign rd       = access & rw;

    assign edge_ev  = s & ~hist;
    assign soft_set = (wr && reg_addr == A_SOFT)    ? wdata_ch : '0;
    assign w1c      = (wr && reg_addr == A_PENDING) ? wdata_ch : '0;
    // The NMI channel is permanently edge-mode, so MODE writes never disturb it.
    assign mode_eff = mode | NMI_MASK;
    assign mode_chg = (wr && reg_addr == A_MODE) ? ((wdata_ch ^ mode) & ~NMI_MASK) : '0;
    assign irq_src  = pending & enable & ~NMI_MASK;

    // Set beats W1C on edge channels; level channels simply mirror s.
    assign pending_next = ((mode_eff & (edge_ev | soft_set | (pending & ~w1c))) |
                           (~mode_eff & s)) & ~mode_chg;
    // Reloading history with the new-polarity level suppresses a spurious edge.
    assign hist_next = (wr && reg_addr == A_POL) ? (sync_q[SYNC_STAGES-1] ^ wdata_ch) : s;

    always_comb begin
        rd_mux  = '0;
        act_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (irq_src[i]) act_idx = 3'(i);
        end
        case (reg_addr)
            A_STATUS:  rd_mux[CHANNELS-1:0] = s;
            A_PENDING: rd_mux[CHANNELS-1:0] = pending;
            A_ENABLE:  rd_mux[CHANNELS-1:0] = enable;
            A_MODE:    rd_mux[CHANNELS-1:0] = mode;
            A_POL:     rd_mux[CHANNELS-1:0] = polarity;
            A_ACTIVE:  rd_mux = {|irq_src, 4'b0000, act_idx};
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q   <= '0;
            hist     <= '0;
            pending  <= '0;
            enable   <= RESET_MASK;
            mode     <= '0;
            polarity <= '0;
            rdata    <= '0;
            irq_n    <= 1'b1;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], src};
            hist    <= hist_next;
            pending <= pending_next;
            irq_n   <= ~|irq_src;
            if (rd) rdata <= rd_mux;
            if (wr) begin
                case (reg_addr)
                    A_ENABLE: enable   <= wdata_ch;
                    A_MODE:   mode     <= wdata_ch;
                    A_POL:    polarity <= wdata_ch;
                    default:  ;
                endcase
            end
        end
    end

`ifdef IRQC_NMI_EN
    localparam int NW = $clog2(NMI_PULSE + 1);

    logic [NW-1:0] nmi_cnt, nmi_cnt_next;

    // A fresh edge reloads the count, so an edge mid-pulse extends it.
    always_comb begin
        nmi_cnt_next = '0;
        if (edge_ev[0])          nmi_cnt_next = NW'(NMI_PULSE);
        else if (nmi_cnt != '0)  nmi_cnt_next = nmi_cnt - NW'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            nmi_cnt <= '0;
            nmi_n   <= 1'b1;
        end else begin
            nmi_cnt <= nmi_cnt_next;
            nmi_n   <= (nmi_cnt_next == '0);
        end
    end
`else
    localparam logic NMI_IDLE = (NMI_PULSE >= 1);

    assign nmi_n = NMI_IDLE;
`endif

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_irq_ctrl;
    localparam int         CH = 8;
    localparam int         SS = 2;
    localparam int         NP = 4;
    localparam logic [7:0] RM = 8'h00;
`ifdef IRQC_NMI_EN
    localparam bit NMI_ON = 1'b1;
`else
    localparam bit NMI_ON = 1'b0;
`endif
    localparam logic [7:0] NMI_BIT = NMI_ON ? 8'h01 : 8'h00;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] src = '0;
    logic       cs = 1'b0, strobe = 1'b0, rw = 1'b1;
    logic [2:0] reg_addr = '0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       irq_n, nmi_n;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    irq_ctrl #(.CHANNELS(CH), .SYNC_STAGES(SS), .RESET_MASK(RM), .NMI_PULSE(NP)) dut (
        .clock(clock), .reset(reset), .src(src), .cs(cs), .strobe(strobe), .rw(rw),
        .reg_addr(reg_addr), .wdata(wdata), .rdata(rdata), .irq_n(irq_n), .nmi_n(nmi_n)
    );

    // ---------------- behavioural reference model ----------------
    logic [7:0] m_pend, m_en, m_mode, m_pol, m_prev, m_rdata;
    logic       m_irq_n, m_nmi_n;
    logic [7:0] src_q[$];
    int         m_cyc, m_nmi_at;
    bit         m_nmi_seen;

    function automatic logic [7:0] reg_view(input logic [2:0] a, input logic [7:0] lvl);
        logic [7:0] v;
        logic [7:0] act;
        v   = 8'h00;
        act = m_pend & m_en & ~NMI_BIT;
        case (a)
            3'd0: v = lvl;
            3'd1: v = m_pend;
            3'd2: v = m_en;
            3'd3: v = m_mode;
            3'd4: v = m_pol;
            3'd5: begin
                for (int i = 0; i < 8; i++) begin
                    if (act[i]) begin
                        v = 8'h80 | 8'(i);
                        break;
                    end
                end
            end
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    always @(posedge clock or negedge reset) begin
        logic [7:0] lvl, rise, nxt;
        bit         acc_w;
        if (!reset) begin
            m_pend = 0; m_en = RM; m_mode = 0; m_pol = 0; m_prev = 0; m_rdata = 0;
            m_irq_n = 1'b1; m_cyc = 0; m_nmi_at = 0; m_nmi_seen = 0;
            src_q.delete();
            for (int i = 0; i < SS; i++) src_q.push_back(8'h00);
        end else begin
            m_cyc++;
            lvl   = src_q[0] ^ m_pol;          // source level as seen SS clocks late
            rise  = lvl & ~m_prev;
            acc_w = cs && strobe && !rw;
            if (cs && strobe && rw) m_rdata = reg_view(reg_addr, lvl);
            m_irq_n = ((m_pend & m_en & ~NMI_BIT) == 8'h00);
            for (int ch = 0; ch < 8; ch++) begin
                if (acc_w && reg_addr == 3'd3 && wdata[ch] != m_mode[ch] && !NMI_BIT[ch])
                    nxt[ch] = 1'b0;
                else if (m_mode[ch] || NMI_BIT[ch]) begin
                    if (rise[ch] || (acc_w && reg_addr == 3'd6 && wdata[ch])) nxt[ch] = 1'b1;
                    else if (acc_w && reg_addr == 3'd1 && wdata[ch])        nxt[ch] = 1'b0;
                    else                                                     nxt[ch] = m_pend[ch];
                end else
                    nxt[ch] = lvl[ch];
            end
            m_pend = nxt;
            if (NMI_ON && rise[0]) begin
                m_nmi_seen = 1;
                m_nmi_at   = m_cyc;
            end
            m_prev = (acc_w && reg_addr == 3'd4) ? (src_q[0] ^ wdata) : lvl;
            if (acc_w) begin
                case (reg_addr)
                    3'd2: m_en   = wdata;
                    3'd3: m_mode = wdata;
                    3'd4: m_pol  = wdata;
                    default: ;
                endcase
            end
            src_q.push_back(src);
            void'(src_q.pop_front());
        end
        m_nmi_n = !(m_nmi_seen && (m_cyc - m_nmi_at) < NP);
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
        cs = 1; strobe = 1; rw = 0; reg_addr = a; wdata = d;
        @(negedge clock);
        cs = 0; strobe = 0; rw = 1;
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [7:0] d);
        cs = 1; strobe = 1; rw = 1; reg_addr = a;
        @(negedge clock);
        cs = 0; strobe = 0;
        d = rdata;
    endtask

    task automatic do_reset();
        cs = 0; strobe = 0; rw = 1; src = 0; reset = 0;
        cyc(3);
        reset = 1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [7:0] d, exp;
        do_reset();
        n_checks++; if (irq_n !== 1'b1) $display("FAIL reset_irq_n: got %b want 1", irq_n); else n_pass++;
        n_checks++; if (nmi_n !== 1'b1) $display("FAIL reset_nmi_n: got %b want 1", nmi_n); else n_pass++;
        n_checks++; if (rdata !== 8'h00) $display("FAIL reset_rdata: got %h want 00", rdata); else n_pass++;
        for (int a = 0; a < 8; a++) begin
            rd_reg(3'(a), d);
            exp = (a == 2) ? RM : 8'h00;
            n_checks++;
            if (d !== exp) $display("FAIL reset_reg%0d: got %h want %h", a, d, exp); else n_pass++;
        end
    endtask

    task automatic test_edge();
        logic [7:0] d;
        wr_reg(3'd2, 8'h04);
        wr_reg(3'd3, 8'h04);
        src[2] = 1;
        cyc(3);
        n_checks++; if (irq_n !== 1'b1) $display("FAIL edge_irq_early: got %b want 1", irq_n); else n_pass++;
        cyc(1);
        n_checks++; if (irq_n !== 1'b0) $display("FAIL edge_irq_low: got %b want 0", irq_n); else n_pass++;
        src[2] = 0;
        rd_reg(3'd1, d);
        n_checks++; if (d !== 8'h04) $display("FAIL edge_pending: got %h want 04", d); else n_pass++;
        rd_reg(3'd5, d);
        n_checks++; if (d !== 8'h82) $display("FAIL edge_active: got %h want 82", d); else n_pass++;
        wr_reg(3'd1, 8'h04);
        n_checks++; if (irq_n !== 1'b0) $display("FAIL edge_w1c_same: got %b want 0", irq_n); else n_pass++;
        cyc(1);
        n_checks++; if (irq_n !== 1'b1) $display("FAIL edge_w1c_release: got %b want 1", irq_n); else n_pass++;
    endtask

    task automatic test_level();
        logic [7:0] d;
        wr_reg(3'd2, 8'h20);
        wr_reg(3'd3, 8'h00);
        src[5] = 1;
        cyc(3);
        n_checks++; if (irq_n !== 1'b1) $display("FAIL level_irq_early: got %b want 1", irq_n); else n_pass++;
        cyc(1);
        n_checks++; if (irq_n !== 1'b0) $display("FAIL level_irq_low: got %b want 0", irq_n); else n_pass++;
        wr_reg(3'd1, 8'h20);
        cyc(1);
        n_checks++; if (irq_n !== 1'b0) $display("FAIL level_w1c_ignored: got %b want 0", irq_n); else n_pass++;
        rd_reg(3'd1, d);
        n_checks++; if (d !== 8'h20) $display("FAIL level_pending: got %h want 20", d); else n_pass++;
        src[5] = 0;
        cyc(3);
        n_checks++; if (irq_n !== 1'b0) $display("FAIL level_fall_early: got %b want 0", irq_n); else n_pass++;
        cyc(1);
        n_checks++; if (irq_n !== 1'b1) $display("FAIL level_fall: got %b want 1", irq_n); else n_pass++;
    endtask

    task automatic test_w1c_race();
        logic [7:0] d;
        wr_reg(3'd3, 8'h02);
        wr_reg(3'd2, 8'h02);
        src[1] = 1;
        cyc(2);
        wr_reg(3'd1, 8'h02);                 // W1C lands on the same edge the event latches
        rd_reg(3'd1, d);
        n_checks++; if (d !== 8'h02) $display("FAIL race_set_wins: got %h want 02", d); else n_pass++;
        n_checks++; if (irq_n !== 1'b0) $display("FAIL race_irq: got %b want 0", irq_n); else n_pass++;
        wr_reg(3'd1, 8'h02);
        rd_reg(3'd1, d);
        n_checks++; if (d !== 8'h00) $display("FAIL race_w1c: got %h want 00", d); else n_pass++;
        src[1] = 0;
        cyc(4);
        wr_reg(3'd4, 8'h02);
        cyc(4);
        rd_reg(3'd1, d);
        n_checks++; if (d !== 8'h00) $display("FAIL pol_no_spurious: got %h want 00", d); else n_pass++;
        rd_reg(3'd0, d);
        n_checks++; if (d !== 8'h02) $display("FAIL pol_status: got %h want 02", d); else n_pass++;
        n_checks++; if (irq_n !== 1'b1) $display("FAIL pol_irq: got %b want 1", irq_n); else n_pass++;
        wr_reg(3'd4, 8'h00);
        cyc(4);
    endtask

    task automatic test_active_soft();
        logic [7:0] d;
        wr_reg(3'd3, 8'h48);
        wr_reg(3'd2, 8'h48);
        src = 8'h48;
        cyc(4);
        src = 8'h00;
        rd_reg(3'd5, d);
        n_checks++; if (d !== 8'h83) $display("FAIL active_lowest: got %h want 83", d); else n_pass++;
        rd_reg(3'd1, d);
        n_checks++; if (d !== 8'h48) $display("FAIL active_pending: got %h want 48", d); else n_pass++;
        wr_reg(3'd3, 8'h08);                 // ch6 turns level: its pending drops
        wr_reg(3'd6, 8'h40);
        rd_reg(3'd1, d);
        n_checks++; if (d !== 8'h08) $display("FAIL soft_level_ignored: got %h want 08", d); else n_pass++;
        rd_reg(3'd6, d);
        n_checks++; if (d !== 8'h00) $display("FAIL soft_reads_zero: got %h want 00", d); else n_pass++;
        wr_reg(3'd3, 8'h0C);
        wr_reg(3'd6, 8'h04);
        rd_reg(3'd1, d);
        n_checks++; if (d !== 8'h0C) $display("FAIL soft_edge_sets: got %h want 0c", d); else n_pass++;
        rd_reg(3'd3, d);
        n_checks++; if (d !== 8'h0C) $display("FAIL mode_readback: got %h want 0c", d); else n_pass++;
        wr_reg(3'd1, 8'hFF);
        wr_reg(3'd3, 8'h00);
        wr_reg(3'd2, 8'h00);
    endtask

    task automatic test_reset_mid_access();
        logic [7:0] d;
        cs = 1; strobe = 1; rw = 0; reg_addr = 3'd2; wdata = 8'hFF;
        #2 reset = 0;
        cyc(2);
        cs = 0; strobe = 0; rw = 1;
        reset = 1;
        rd_reg(3'd2, d);
        n_checks++; if (d !== RM) $display("FAIL midreset_enable: got %h want %h", d, RM); else n_pass++;
        n_checks++; if (irq_n !== 1'b1) $display("FAIL midreset_irq: got %b want 1", irq_n); else n_pass++;
    endtask

    task automatic test_nmi();
        logic [7:0] d;
        do_reset();
        wr_reg(3'd2, 8'h01);
`ifdef IRQC_NMI_EN
        src[0] = 1;
        cyc(2);
        n_checks++; if (nmi_n !== 1'b1) $display("FAIL nmi_early: got %b want 1", nmi_n); else n_pass++;
        for (int k = 0; k < NP; k++) begin
            cyc(1);
            n_checks++; if (nmi_n !== 1'b0) $display("FAIL nmi_low_%0d: got %b want 0", k, nmi_n); else n_pass++;
            n_checks++; if (irq_n !== 1'b1) $display("FAIL nmi_irq_%0d: got %b want 1", k, irq_n); else n_pass++;
        end
        cyc(1);
        n_checks++; if (nmi_n !== 1'b1) $display("FAIL nmi_end: got %b want 1", nmi_n); else n_pass++;
        rd_reg(3'd1, d);
        n_checks++; if (d !== 8'h01) $display("FAIL nmi_pending: got %h want 01", d); else n_pass++;
        src[0] = 0;
        cyc(3);
        src[0] = 1;
        cyc(4);
        n_checks++; if (nmi_n !== 1'b0) $display("FAIL nmi_second: got %b want 0", nmi_n); else n_pass++;
        reset = 0;
        #1;
        n_checks++; if (nmi_n !== 1'b1) $display("FAIL nmi_reset: got %b want 1", nmi_n); else n_pass++;
        cyc(2);
        src = 0;
        reset = 1;
`else
        wr_reg(3'd3, 8'h01);
        src[0] = 1;
        cyc(4);
        n_checks++; if (irq_n !== 1'b0) $display("FAIL ch0_irq: got %b want 0", irq_n); else n_pass++;
        n_checks++; if (nmi_n !== 1'b1) $display("FAIL ch0_nmi_tied: got %b want 1", nmi_n); else n_pass++;
        src[0] = 0;
        wr_reg(3'd1, 8'h01);
        cyc(1);
        n_checks++; if (irq_n !== 1'b1) $display("FAIL ch0_clear: got %b want 1", irq_n); else n_pass++;
        rd_reg(3'd1, d);
        n_checks++; if (d !== 8'h00) $display("FAIL ch0_pending: got %h want 00", d); else n_pass++;
`endif
    endtask

    task automatic test_random();
        int idx;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            n_checks++; if (irq_n !== m_irq_n) $display("FAIL rand_irq_n @%0d: got %b want %b", k, irq_n, m_irq_n); else n_pass++;
            n_checks++; if (nmi_n !== m_nmi_n) $display("FAIL rand_nmi_n @%0d: got %b want %b", k, nmi_n, m_nmi_n); else n_pass++;
            n_checks++; if (rdata !== m_rdata) $display("FAIL rand_rdata @%0d: got %h want %h", k, rdata, m_rdata); else n_pass++;
            if ($urandom_range(0, 3) == 0) begin
                idx = $urandom_range(0, 7);
                src[idx] = ~src[idx];
            end
            cs       = ($urandom_range(0, 2) != 0);
            strobe   = ($urandom_range(0, 1) != 0);
            rw       = ($urandom_range(0, 1) != 0);
            reg_addr = 3'($urandom_range(0, 7));
            wdata    = 8'($urandom);
            @(negedge clock);
        end
        cs = 0; strobe = 0; rw = 1;
    endtask

    initial begin
        test_reset();
        test_edge();
        test_level();
        test_w1c_race();
        test_active_soft();
        test_reset_mid_access();
        test_nmi();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end
endmodule
